// File: rtl/cv32e40n_data_arbiter.sv
// cv32e40n_data_arbiter: arbitrates several OBI data masters onto one slave port,
// with bus lock, request hold while ungranted, and a FIFO that routes responses back.
module cv32e40n_data_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_MASTERS-1:0]          m_req_i,
    input  logic [NUM_MASTERS-1:0]          m_lock_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]          m_gnt_o,
    output logic [NUM_MASTERS-1:0]          m_rvalid_o,
    output logic [DATA_WIDTH-1:0]           m_rdata_o,
    output logic                            s_req_o,
    output logic [ADDR_WIDTH-1:0]           s_addr_o,
    output logic                            s_we_o,
    output logic [DATA_WIDTH/8-1:0]         s_be_o,
    output logic [DATA_WIDTH-1:0]           s_wdata_o,
    input  logic                            s_gnt_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           s_rdata_i,
    output logic                            err_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0]          fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [IW-1:0]          rr_ptr, base, pend_sel, lock_sel, arb_sel, sel;
    logic                   pend_valid, lock_valid, lock_active, arb_valid, sel_valid;
    logic                   full, push, pop;
    logic [NUM_MASTERS-1:0] eligible;

    // The lock only holds while its owner keeps m_lock_i high; the release cycle arbitrates freely.
    assign lock_active = lock_valid && m_lock_i[lock_sel];
    assign eligible    = lock_active ? m_req_i & (NUM_MASTERS'(1) << lock_sel) : m_req_i;
    assign base        = ARB_MODE == 1 ? rr_ptr : '0;

    // Scan offsets from the top down so the smallest offset from base wins.
    always_comb begin
        arb_sel   = '0;
        arb_valid = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (eligible[(i + int'(base)) % NUM_MASTERS]) begin
                arb_sel   = IW'((i + int'(base)) % NUM_MASTERS);
                arb_valid = 1'b1;
            end
        end
    end

    assign sel        = pend_valid ? pend_sel : arb_sel;
    assign sel_valid  = pend_valid || arb_valid;
    assign full       = count == CW'(MAX_OUTSTANDING);
    assign s_req_o    = !rst_i && sel_valid && !full;
    assign push       = s_req_o && s_gnt_i;
    assign pop        = !rst_i && s_rvalid_i && count != '0;
    assign s_addr_o   = m_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_we_o     = m_we_i[sel];
    assign s_be_o     = m_be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
    assign s_wdata_o  = m_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign m_gnt_o    = push ? NUM_MASTERS'(1) << sel : '0;
    assign m_rvalid_o = pop ? NUM_MASTERS'(1) << fifo_q[rd_ptr] : '0;
    assign m_rdata_o  = s_rdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rr_ptr     <= '0;
            pend_valid <= 1'b0;
            pend_sel   <= '0;
            lock_valid <= 1'b0;
            lock_sel   <= '0;
            err_o      <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= sel;
                wr_ptr <= wr_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + 1'b1;
                rr_ptr <= sel == IW'(NUM_MASTERS - 1) ? '0 : sel + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + 1'b1;
            count      <= count + CW'(push) - CW'(pop);
            pend_valid <= s_req_o && !s_gnt_i;
            if (s_req_o && !s_gnt_i)
                pend_sel <= sel;
            lock_valid <= push ? m_lock_i[sel] : lock_active;
            if (push && m_lock_i[sel])
                lock_sel <= sel;
            err_o <= err_o || (s_rvalid_i && count == '0);
        end
    end
endmodule
